ili9341_reader: RTL and testbench
=================================

Name: ili9341_reader

Overview:
- Serial read engine for the ILI9341 4-wire SPI interface; the receive-side counterpart to the power-on initialiser.
- Issues one read command byte with DC low, clocks the controller-specified dummy bits, then shifts in 1–4 response bytes from the panel's SDO pin.
- Used after the initialiser asserts ready, for ID checks (0x04, 0xD3) and status reads (0x09, 0x0A).
- Owns CS/DC/SCLK/MOSI only while busy; top level muxes pins between this block and the writer.

Parameters:
- CLK_HALF, 1: clk cycles per SCLK half-period (≥1). Bit time is 2*CLK_HALF clk cycles.
- CS_GAP, 2: clk cycles CS is held high after the last bit, before done.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous active-high reset.
- start  input  1  request a read transaction; sampled only while busy=0.
- cmd  input  8  command byte, sent MSB first.
- num_bytes  input  3  bytes to read; 0 is treated as 1, values above 4 as 4.
- dummy_bits  input  4  dummy SCLK cycles between command and data; values above 8 are treated as 8.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle pulse when rdata is valid.
- rdata  output  32  received bytes, right-aligned; first byte is most significant; unused upper bytes are 0.
- lcd_cs  output  1  chip select, active low.
- lcd_dc  output  1  0 = command phase, 1 = dummy/data phase.
- lcd_sclk  output  1  serial clock; idle low.
- lcd_mosi  output  1  serial data to panel.
- lcd_miso  input  1  serial data from panel.

Behaviour:
- Reset values: lcd_cs=1, lcd_sclk=0, lcd_dc=1, lcd_mosi=0, busy=0, done=0, rdata=0; state IDLE.
- Reset mid-transaction aborts immediately: CS rises next edge, no done pulse, rdata unchanged from its reset value of 0.
- States and transitions:
  - IDLE → CMD on start=1. At that edge: cmd, clamped num_bytes and clamped dummy_bits are latched; busy=1; lcd_cs=0; lcd_dc=0; lcd_mosi=cmd[7]. start while busy is ignored.
  - CMD: 8 bits. Each bit is a low phase (SCLK=0, CLK_HALF cycles, MOSI stable) followed by a high phase (SCLK=1, CLK_HALF cycles). MOSI changes only at the edge where SCLK falls or the phase begins.
  - CMD → DUMMY, or → DATA if dummy count is 0: lcd_dc=1 and lcd_mosi=0 at the same edge SCLK returns low.
  - DUMMY: dummy-count bits with the same bit timing; lcd_miso is ignored.
  - DATA: 8*N bits. lcd_miso is sampled on the clk edge that ends each SCLK high phase and shifted into the LSB of a 32-bit shift register cleared at start.
  - DATA → GAP after the last bit: lcd_cs=1, lcd_sclk=0. GAP lasts CS_GAP cycles.
  - GAP → IDLE: rdata loads the shift register, done=1 for one cycle, busy=0 in the same cycle.
- Latency, accepting edge to done: 1 + 2*CLK_HALF*(8 + D + 8*N) + CS_GAP cycles, where D and N are the clamped values.
- A new start may be accepted in the cycle done is high.
- rdata holds its value between transactions.
- SCLK never glitches: exactly 8 + D + 8*N rising edges per transaction.

Test Plan:
- Reset during DATA (CLK_HALF=1) → next edge lcd_cs=1, sclk=0, busy=0; no done pulse; rdata=0.
- cmd=0x04, N=3, D=1; panel model returns 0x00,0x93,0x41 → done after 1+2*(8+1+24)+2 = 69 cycles; rdata=0x00009341; MOSI bits 00000100; exactly 33 SCLK rises.
- cmd=0x09, N=4, D=1, model returns 0x80,0x53,0x04,0x00 → rdata=0x80530400; DC low for the first 8 SCLK rises only.
- num_bytes=0, dummy_bits=15, cmd=0x0A, model returns 0x9C → treated as N=1, D=8; 24 SCLK rises; rdata=0x0000009C.
- start pulsed again mid-transaction → ignored. Back-to-back start in the done cycle → second transaction's CS falls the following edge.
- CLK_HALF=3, cmd=0xD3, N=4, D=1 → SCLK high and low phases each 3 cycles; done at 1+6*41+2 = 249 cycles.

Source files
------------

// File: rtl/ili9341_reader.sv
// ILI9341 4-wire SPI read engine: sends one command byte, clocks dummy bits,
// then shifts 1-4 response bytes in from the panel's SDO line.
module ili9341_reader #(
   parameter int CLK_HALF = 1,
   parameter int CS_GAP   = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [7:0]  cmd,
   input  logic [2:0]  num_bytes,
   input  logic [3:0]  dummy_bits,
   output logic        busy,
   output logic        done,
   output logic [31:0] rdata,
   output logic        lcd_cs,
   output logic        lcd_dc,
   output logic        lcd_sclk,
   output logic        lcd_mosi,
   input  logic        lcd_miso
);

   localparam int PW = (CLK_HALF > 1) ? $clog2(CLK_HALF) : 1;
   localparam int GW = (CS_GAP > 0) ? $clog2(CS_GAP + 1) : 1;

   typedef enum logic [2:0] {S_IDLE, S_CMD, S_DUMMY, S_DATA, S_GAP} state_t;

   state_t        state_q, state_d;
   logic [PW-1:0] ph_q, ph_d;
   logic [4:0]    bit_q, bit_d;
   logic [4:0]    last_q, last_d;
   logic [3:0]    dcnt_q, dcnt_d;
   logic [GW-1:0] gap_q, gap_d;
   logic [6:0]    cmd_q, cmd_d;
   logic [31:0]   shift_q, shift_d;
   logic [31:0]   rdata_q, rdata_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic          cs_q, cs_d;
   logic          dc_q, dc_d;
   logic          sclk_q, sclk_d;
   logic          mosi_q, mosi_d;

   logic [2:0]    n_clamp;
   logic [1:0]    n_m1;
   logic [3:0]    d_clamp;
   logic          phase_end;
   logic          bit_end;

   always_comb begin
      n_clamp = num_bytes;
      if (num_bytes == 3'd0)
         n_clamp = 3'd1;
      else if (num_bytes > 3'd4)
         n_clamp = 3'd4;
      n_m1    = 2'(n_clamp - 3'd1);
      d_clamp = (dummy_bits > 4'd8) ? 4'd8 : dummy_bits;
   end

   // A bit ends on the clk edge that closes its SCLK high phase.
   assign phase_end = (ph_q == PW'(CLK_HALF - 1));
   assign bit_end   = phase_end && sclk_q;

   always_comb begin
      state_d = state_q;
      ph_d    = ph_q;
      bit_d   = bit_q;
      last_d  = last_q;
      dcnt_d  = dcnt_q;
      gap_d   = gap_q;
      cmd_d   = cmd_q;
      shift_d = shift_q;
      rdata_d = rdata_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      cs_d    = cs_q;
      dc_d    = dc_q;
      sclk_d  = sclk_q;
      mosi_d  = mosi_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_CMD;
               cmd_d   = cmd[6:0];
               last_d  = {n_m1, 3'b111};
               dcnt_d  = d_clamp;
               shift_d = '0;
               ph_d    = '0;
               bit_d   = '0;
               busy_d  = 1'b1;
               cs_d    = 1'b0;
               dc_d    = 1'b0;
               sclk_d  = 1'b0;
               mosi_d  = cmd[7];
            end
         end

         S_CMD, S_DUMMY, S_DATA: begin
            if (phase_end) begin
               ph_d   = '0;
               sclk_d = ~sclk_q;
            end else begin
               ph_d = ph_q + PW'(1);
            end

            if (bit_end) begin
               bit_d = bit_q + 5'd1;
               case (state_q)
                  S_CMD: begin
                     mosi_d = cmd_q[6];
                     cmd_d  = {cmd_q[5:0], 1'b0};
                     if (bit_q == 5'd7) begin
                        bit_d   = '0;
                        dc_d    = 1'b1;
                        mosi_d  = 1'b0;
                        state_d = (dcnt_q == 4'd0) ? S_DATA : S_DUMMY;
                     end
                  end
                  S_DUMMY: begin
                     if ((bit_q + 5'd1) == {1'b0, dcnt_q}) begin
                        bit_d   = '0;
                        state_d = S_DATA;
                     end
                  end
                  default: begin
                     shift_d = {shift_q[30:0], lcd_miso};
                     if (bit_q == last_q) begin
                        state_d = S_GAP;
                        cs_d    = 1'b1;
                        gap_d   = '0;
                     end
                  end
               endcase
            end
         end

         S_GAP: begin
            if (gap_q == GW'(CS_GAP)) begin
               state_d = S_IDLE;
               rdata_d = shift_q;
               done_d  = 1'b1;
               busy_d  = 1'b0;
            end else begin
               gap_d = gap_q + GW'(1);
            end
         end

         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         ph_q    <= '0;
         bit_q   <= '0;
         last_q  <= '0;
         dcnt_q  <= '0;
         gap_q   <= '0;
         cmd_q   <= '0;
         shift_q <= '0;
         rdata_q <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         cs_q    <= 1'b1;
         dc_q    <= 1'b1;
         sclk_q  <= 1'b0;
         mosi_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ph_q    <= ph_d;
         bit_q   <= bit_d;
         last_q  <= last_d;
         dcnt_q  <= dcnt_d;
         gap_q   <= gap_d;
         cmd_q   <= cmd_d;
         shift_q <= shift_d;
         rdata_q <= rdata_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         cs_q    <= cs_d;
         dc_q    <= dc_d;
         sclk_q  <= sclk_d;
         mosi_q  <= mosi_d;
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign rdata    = rdata_q;
   assign lcd_cs   = cs_q;
   assign lcd_dc   = dc_q;
   assign lcd_sclk = sclk_q;
   assign lcd_mosi = mosi_q;

endmodule

// File: tb/tb_ili9341_reader.sv
// Bench for ili9341_reader: two instances (CLK_HALF=1 and 3) share one panel
// model; expected results are queued at start and checked at done.
module tb_ili9341_reader;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        sel = 1'b0;
   logic [7:0]  cmd = '0;
   logic [2:0]  num_bytes = '0;
   logic [3:0]  dummy_bits = '0;
   logic        miso = 1'b0;

   logic        busy1, done1, cs1, dc1, sclk1, mosi1;
   logic        busy3, done3, cs3, dc3, sclk3, mosi3;
   logic [31:0] rdata1, rdata3;
   logic        start1, start3;
   logic        busy_m, done_m, cs_m, dc_m, sclk_m, mosi_m;
   logic [31:0] rdata_m;

   assign start1  = start & ~sel;
   assign start3  = start & sel;
   assign busy_m  = sel ? busy3  : busy1;
   assign done_m  = sel ? done3  : done1;
   assign cs_m    = sel ? cs3    : cs1;
   assign dc_m    = sel ? dc3    : dc1;
   assign sclk_m  = sel ? sclk3  : sclk1;
   assign mosi_m  = sel ? mosi3  : mosi1;
   assign rdata_m = sel ? rdata3 : rdata1;

   ili9341_reader #(.CLK_HALF(1), .CS_GAP(2)) dut1 (
      .clk(clk), .rst(rst), .start(start1), .cmd(cmd), .num_bytes(num_bytes),
      .dummy_bits(dummy_bits), .busy(busy1), .done(done1), .rdata(rdata1),
      .lcd_cs(cs1), .lcd_dc(dc1), .lcd_sclk(sclk1), .lcd_mosi(mosi1), .lcd_miso(miso));

   ili9341_reader #(.CLK_HALF(3), .CS_GAP(2)) dut3 (
      .clk(clk), .rst(rst), .start(start3), .cmd(cmd), .num_bytes(num_bytes),
      .dummy_bits(dummy_bits), .busy(busy3), .done(done3), .rdata(rdata3),
      .lcd_cs(cs3), .lcd_dc(dc3), .lcd_sclk(sclk3), .lcd_mosi(mosi3), .lcd_miso(miso));

   always #5 clk = ~clk;

   // Panel model: records MOSI/DC at each SCLK rise, presents response bits MSB first.
   int          rises_total = 0;
   int          base = 0;
   int          cur_n = 1;
   int          cur_d = 0;
   logic [31:0] cur_resp = '0;
   bit          mosi_at [64];
   bit          dc_at   [64];

   always @(posedge sclk_m) begin
      int rel;
      int k;
      rel = rises_total - base;
      if (rel >= 0 && rel < 64) begin
         mosi_at[rel] = mosi_m;
         dc_at[rel]   = dc_m;
      end
      k = rel - 8 - cur_d;
      if (k >= 0 && k < cur_n * 8)
         miso = cur_resp[cur_n * 8 - 1 - k];
      rises_total = rises_total + 1;
   end

   typedef struct {
      logic [7:0]  cmd;
      logic [2:0]  nb;
      logic [3:0]  db;
      bit          ch3;
      logic [31:0] resp;
      int          neff;
      int          deff;
      logic [31:0] exp_rdata;
      int          exp_lat;
      bit          poke;
      bit          b2b;
   } vec_t;

   typedef struct {
      logic [31:0] rdata;
      int          lat;
      int          rises;
   } exp_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_err = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   task automatic run_vec(input vec_t v, input vec_t nx, input bit pre, output bit pre_out);
      int   cyc, run, ch, nr;
      int   hi_min, hi_max, lo_min, lo_max;
      logic last;
      logic [7:0] cap;
      bit   mbad, dbad;
      exp_t e;

      sel      = v.ch3;
      ch       = v.ch3 ? 3 : 1;
      base     = rises_total;
      cur_n    = v.neff;
      cur_d    = v.deff;
      cur_resp = v.resp;
      if (!pre) begin
         @(negedge clk);
         cmd = v.cmd; num_bytes = v.nb; dummy_bits = v.db; start = 1'b1;
      end
      e.rdata = v.exp_rdata;
      e.lat   = v.exp_lat;
      e.rises = 8 + v.deff + 8 * v.neff;
      sb.push_back(e);

      @(posedge clk); #1;
      start = 1'b0;
      chk("accept_cs_busy_done", {29'd0, cs_m, busy_m, done_m}, 32'd2);

      cyc = 0; run = 1; last = sclk_m;
      hi_min = 999; hi_max = 0; lo_min = 999; lo_max = 0;
      while (!done_m && cyc < 3000) begin
         @(posedge clk); #1;
         cyc++;
         if (v.poke && cyc == 12) begin
            start = 1'b1; cmd = 8'hFF; num_bytes = 3'd1; dummy_bits = 4'd0;
         end
         if (v.poke && cyc == 13) start = 1'b0;
         if (sclk_m === last) run++;
         else begin
            if (last) begin
               if (run < hi_min) hi_min = run;
               if (run > hi_max) hi_max = run;
            end else begin
               if (run < lo_min) lo_min = run;
               if (run > lo_max) lo_max = run;
            end
            run = 1;
            last = sclk_m;
         end
      end
      if (!done_m) chk("done_timeout", 32'd0, 32'd1);

      nr = rises_total - base;
      cap = '0; mbad = 1'b0; dbad = 1'b0;
      for (int i = 0; i < nr && i < 64; i++) begin
         if (i < 8) cap = {cap[6:0], mosi_at[i]};
         else if (mosi_at[i]) mbad = 1'b1;
         if ((i < 8) == dc_at[i]) dbad = 1'b1;
      end

      e = sb.pop_front();
      chk("rdata", rdata_m, e.rdata);
      chk("latency", cyc, e.lat);
      chk("sclk_rises", nr, e.rises);
      chk("mosi_cmd_bits", {24'd0, cap}, {24'd0, v.cmd});
      chk("mosi_low_after_cmd", {31'd0, mbad}, 32'd0);
      chk("dc_low_first8_only", {31'd0, dbad}, 32'd0);
      chk("busy_low_in_done", {31'd0, busy_m}, 32'd0);
      chk("sclk_high_min", hi_min, ch);
      chk("sclk_high_max", hi_max, ch);
      chk("sclk_low_min", lo_min, ch);
      chk("sclk_low_max", lo_max, ch);

      if (v.b2b) begin
         cmd = nx.cmd; num_bytes = nx.nb; dummy_bits = nx.db; start = 1'b1;
         pre_out = 1'b1;
      end else begin
         @(posedge clk); #1;
         chk("done_one_cycle", {31'd0, done_m}, 32'd0);
         pre_out = 1'b0;
      end
   endtask

   localparam int NV = 6;
   vec_t tbl [NV];

   initial begin
      bit pre;
      bit dn;

      //          cmd    nb    db     ch3  resp          neff deff exp_rdata     lat  poke b2b
      tbl[0] = '{8'h04, 3'd3, 4'd1,  1'b0, 32'h0000_9341, 3, 1, 32'h0000_9341, 69,  1'b0, 1'b1};
      tbl[1] = '{8'h09, 3'd4, 4'd1,  1'b0, 32'h8053_0400, 4, 1, 32'h8053_0400, 85,  1'b0, 1'b0};
      tbl[2] = '{8'h0A, 3'd0, 4'd15, 1'b0, 32'h0000_009C, 1, 8, 32'h0000_009C, 51,  1'b0, 1'b0};
      tbl[3] = '{8'hD3, 3'd4, 4'd1,  1'b1, 32'h0093_4100, 4, 1, 32'h0093_4100, 249, 1'b0, 1'b0};
      tbl[4] = '{8'h3C, 3'd7, 4'd0,  1'b0, 32'hDEAD_BEEF, 4, 0, 32'hDEAD_BEEF, 83,  1'b1, 1'b0};
      tbl[5] = '{8'hA5, 3'd2, 4'd0,  1'b1, 32'h0000_BEEF, 2, 0, 32'h0000_BEEF, 147, 1'b0, 1'b0};

      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_pins_ch1", {26'd0, cs1, sclk1, dc1, mosi1, busy1, done1}, 32'b101000);
      chk("reset_rdata_ch1", rdata1, 32'd0);
      chk("reset_pins_ch3", {26'd0, cs3, sclk3, dc3, mosi3, busy3, done3}, 32'b101000);
      chk("reset_rdata_ch3", rdata3, 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // Abort in the DATA phase: pins return to idle at once, no done follows.
      sel = 1'b0; base = rises_total; cur_n = 3; cur_d = 1; cur_resp = 32'h00FF_FFFF;
      @(negedge clk);
      cmd = 8'h04; num_bytes = 3'd3; dummy_bits = 4'd1; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (30) @(posedge clk);
      #1;
      chk("busy_before_abort", {31'd0, busy1}, 32'd1);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      chk("abort_cs_sclk_busy_done", {28'd0, cs1, sclk1, busy1, done1}, 32'b1000);
      chk("abort_rdata", rdata1, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      dn = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(posedge clk); #1;
         if (done1 || !cs1) dn = 1'b1;
      end
      chk("no_done_after_abort", {31'd0, dn}, 32'd0);

      pre = 1'b0;
      for (int i = 0; i < NV; i++)
         run_vec(tbl[i], tbl[(i + 1 < NV) ? i + 1 : i], pre, pre);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
